// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared constants and helpers for the TRNG word source
package trng_pkg;

  localparam logic [1:0] VN_EMIT0 = 2'b01;
  localparam logic [1:0] VN_EMIT1 = 2'b10;

  localparam int DEF_FIFO_DEPTH = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Occupancy needs one bit more than the address so full and empty differ
  function automatic int fifo_lvl_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  typedef enum logic {
    RSP_IDLE    = 1'b0,
    RSP_DELIVER = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/trng_word_fifo.sv
// rtl/trng_word_fifo.sv - word FIFO with flush; pop frees a slot for a same-cycle push
module trng_word_fifo
  import trng_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  input  logic                          flush,
  output logic [WIDTH-1:0]              head,
  output logic                          full,
  output logic                          empty,
  output logic [fifo_lvl_w(DEPTH)-1:0]  level
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    wr_ptr;
  logic [LW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == FULL_LVL);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/trng_word_source.sv
// rtl/trng_word_source.sv - von Neumann debiased TRNG word producer with health test
module trng_word_source
  import trng_pkg::*;
#(
  parameter int TRNG_WIDTH = 4,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int SAMPLE_DIV = 1,
  parameter int REP_LIMIT  = 32
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               en,
  input  logic                               raw_bit,
  input  logic                               trng_req,
  output logic                               trng_valid,
  output logic [TRNG_WIDTH-1:0]              trng_word,
  output logic                               health_fail,
  output logic [fifo_lvl_w(FIFO_DEPTH)-1:0]  fill_level
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? clog2(SAMPLE_DIV) : 1;
  localparam int REP_W = clog2(REP_LIMIT) + 1;
  localparam int CNT_W = clog2(TRNG_WIDTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [REP_W-1:0] REP_MAX  = REP_W'(REP_LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRNG_WIDTH - 1);

  logic [1:0]            sync_q;
  logic [DIV_W-1:0]      div_cnt;
  logic                  sample_tick;
  logic                  sample;
  logic                  prev_sample;
  logic [REP_W-1:0]      rep_cnt;
  logic [REP_W-1:0]      rep_next;
  logic                  health_trip;
  logic                  vn_have;
  logic                  vn_first;
  logic [1:0]            vn_pair;
  logic                  vn_emit;
  logic                  vn_bit;
  logic [TRNG_WIDTH-1:0] pk_word;
  logic [TRNG_WIDTH-1:0] pk_shifted;
  logic [CNT_W-1:0]      pk_cnt;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [TRNG_WIDTH-1:0] fifo_head;
  rsp_state_t            rsp_state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[0], raw_bit};
  end

  assign sample      = sync_q[1];
  assign sample_tick = en && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                  div_cnt <= '0;
    else if (!en || sample_tick)  div_cnt <= '0;
    else                          div_cnt <= div_cnt + 1'b1;
  end

  // rep_cnt == 0 means no previous sample since reset; saturate once failed
  always_comb begin
    rep_next = REP_W'(1);
    if (rep_cnt != '0 && sample == prev_sample)
      rep_next = (rep_cnt == REP_MAX) ? rep_cnt : rep_cnt + 1'b1;
  end

  assign health_trip = sample_tick && !health_fail && (rep_next == REP_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_sample <= 1'b0;
      rep_cnt     <= '0;
      health_fail <= 1'b0;
    end else begin
      if (sample_tick) begin
        prev_sample <= sample;
        rep_cnt     <= rep_next;
      end
      if (health_trip) health_fail <= 1'b1;
    end
  end

  assign vn_pair = {vn_first, sample};
  assign vn_emit = sample_tick && vn_have && (vn_pair == VN_EMIT0 || vn_pair == VN_EMIT1);
  assign vn_bit  = (vn_pair == VN_EMIT1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vn_have  <= 1'b0;
      vn_first <= 1'b0;
    end else if (!en) begin
      vn_have  <= 1'b0;
    end else if (sample_tick) begin
      if (!vn_have) begin
        vn_have  <= 1'b1;
        vn_first <= sample;
      end else begin
        vn_have  <= 1'b0;
      end
    end
  end

  assign pk_shifted = {pk_word[TRNG_WIDTH-2:0], vn_bit};
  assign push = vn_emit && !health_fail && !health_trip && (pk_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pk_word <= '0;
      pk_cnt  <= '0;
    end else if (!en || health_fail || health_trip) begin
      pk_word <= '0;
      pk_cnt  <= '0;
    end else if (vn_emit) begin
      pk_word <= pk_shifted;
      pk_cnt  <= (pk_cnt == CNT_LAST) ? '0 : pk_cnt + 1'b1;
    end
  end

  // A delivery never coincides with a health trip so nothing escapes the flush
  assign pop = (rsp_state == RSP_IDLE) && trng_req && !fifo_empty
               && !health_fail && !health_trip;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_state  <= RSP_IDLE;
      trng_valid <= 1'b0;
      trng_word  <= '0;
    end else begin
      case (rsp_state)
        RSP_IDLE: begin
          if (pop) begin
            rsp_state  <= RSP_DELIVER;
            trng_valid <= 1'b1;
            trng_word  <= fifo_head;
          end
        end
        RSP_DELIVER: begin
          rsp_state  <= RSP_IDLE;
          trng_valid <= 1'b0;
        end
        default: begin
          rsp_state  <= RSP_IDLE;
          trng_valid <= 1'b0;
        end
      endcase
    end
  end

  trng_word_fifo #(
    .WIDTH (TRNG_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push && (!fifo_full || pop)),
    .push_data (pk_shifted),
    .pop       (pop),
    .flush     (health_trip),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fill_level)
  );

endmodule

// File: tb/tb_trng_word_source.sv
// tb/tb_trng_word_source.sv - self-checking bench for trng_word_source
module tb_trng_word_source;

  localparam int W   = 4;
  localparam int D   = 4;
  localparam int SD  = 1;
  localparam int REP = 8;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         en = 1'b0;
  logic         raw_bit = 1'b0;
  logic         trng_req = 1'b0;
  logic         trng_valid;
  logic [W-1:0] trng_word;
  logic         health_fail;
  logic [2:0]   fill_level;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  logic [W-1:0] last_word = '0;
  bit seq[$];

  always #5 clk = ~clk;

  trng_word_source #(
    .TRNG_WIDTH (W),
    .FIFO_DEPTH (D),
    .SAMPLE_DIV (SD),
    .REP_LIMIT  (REP)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .en          (en),
    .raw_bit     (raw_bit),
    .trng_req    (trng_req),
    .trng_valid  (trng_valid),
    .trng_word   (trng_word),
    .health_fail (health_fail),
    .fill_level  (fill_level)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sample stream -> run length, pairs -> bits, bits -> words, words -> queue
  bit           m_r1, m_r2, m_last, m_hf, m_firstv, m_fail, m_valid;
  int           m_run, m_nb, m_div;
  logic [W-1:0] m_acc, m_word;
  logic [W-1:0] mq[$];

  always @(posedge clk or negedge resetn) begin
    bit smp, tick, trip, emit, eb, push, deliver;
    logic [W-1:0] pw;
    if (!resetn) begin
      m_r1 = 0; m_r2 = 0; m_last = 0; m_hf = 0; m_firstv = 0; m_fail = 0;
      m_valid = 0; m_run = 0; m_nb = 0; m_div = 0; m_acc = '0; m_word = '0;
      mq.delete();
    end else begin
      smp = m_r2; m_r2 = m_r1; m_r1 = raw_bit;
      tick = 0; trip = 0; emit = 0; eb = 0; push = 0; pw = '0;
      if (!en) m_div = 0;
      else if (m_div == SD - 1) begin tick = 1; m_div = 0; end
      else m_div++;
      if (tick) begin
        m_run = (m_run > 0 && smp == m_last) ? m_run + 1 : 1;
        m_last = smp;
        if (!m_fail && m_run >= REP) trip = 1;
        if (!m_hf) begin m_hf = 1; m_firstv = smp; end
        else begin
          m_hf = 0;
          if (m_firstv != smp) begin emit = 1; eb = m_firstv; end
        end
      end
      if (!en) m_hf = 0;
      if (!en || m_fail || trip) begin m_nb = 0; m_acc = '0; end
      else if (emit) begin
        m_acc = W'((m_acc * 2 + eb) % (1 << W));
        m_nb++;
        if (m_nb == W) begin push = 1; pw = m_acc; m_nb = 0; end
      end
      deliver = !m_valid && trng_req && mq.size() > 0 && !m_fail && !trip;
      if (m_valid) m_valid = 0;
      else if (deliver) begin m_valid = 1; m_word = mq.pop_front(); end
      if (push && mq.size() < D) mq.push_back(pw);
      if (trip) begin mq.delete(); m_fail = 1; end
    end
  end

  always @(negedge clk) begin
    chk("valid", trng_valid, m_valid);
    chk("word", trng_word, m_word);
    chk("fill_level", fill_level, mq.size());
    chk("health_fail", health_fail, m_fail);
    if (trng_valid) begin
      pulse_cnt++;
      last_word = trng_word;
    end
  end

  task automatic reset_dut();
    resetn = 1'b0; trng_req = 1'b0; en = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic add_word(input logic [W-1:0] w);
    for (int b = W - 1; b >= 0; b--) begin
      if (w[b]) begin seq.push_back(1); seq.push_back(0); end
      else      begin seq.push_back(0); seq.push_back(1); end
    end
  endtask

  // raw_bit reaches the sampler two edges later, so en rises two cycles in
  task automatic run_seq();
    int n;
    n = seq.size();
    for (int i = 0; i < n + 2; i++) begin
      raw_bit = (i < n) ? seq[i] : 1'b0;
      en = (i >= 2);
      @(negedge clk);
    end
    en = 1'b0;
    seq.delete();
  endtask

  task automatic do_req(output logic [W-1:0] w, output int lat);
    w = '0; lat = -1; trng_req = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (trng_valid) begin w = trng_word; lat = k; break; end
    end
    @(negedge clk);
    chk("no_double_valid", trng_valid, 0);
    trng_req = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] exp_words[5];
    int lat, p0, mode;
    bit seen;

    repeat (2) @(negedge clk);
    resetn = 1'b1;
    chk("reset_valid", trng_valid, 0);
    chk("reset_word", trng_word, 0);
    chk("reset_fill", fill_level, 0);
    chk("reset_fail", health_fail, 0);

    // pairs 10,01,10,10 -> 4'hB
    add_word(4'hB); run_seq();
    chk("t1_fill", fill_level, 1);
    do_req(w, lat);
    chk("t1_word", w, 4'hB);
    chk("t1_latency", lat, 1);
    chk("t1_fill_after", fill_level, 0);

    // discarded pairs then 01 x4 -> 4'h0
    for (int i = 0; i < 2; i++) begin
      seq.push_back(0); seq.push_back(0); seq.push_back(1); seq.push_back(1);
    end
    for (int i = 0; i < 4; i++) begin seq.push_back(0); seq.push_back(1); end
    run_seq();
    chk("t2_fill", fill_level, 1);
    do_req(w, lat);
    chk("t2_word", w, 0);
    chk("t2_latency", lat, 1);

    reset_dut();
    exp_words[0] = 4'hA; exp_words[1] = 4'hB; exp_words[2] = 4'hC;
    exp_words[3] = 4'hD; exp_words[4] = 4'hE;
    for (int i = 0; i < 5; i++) begin add_word(exp_words[i]); run_seq(); end
    chk("t3_fill_full", fill_level, 4);
    chk("t3_model_depth", mq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      do_req(w, lat);
      chk("t3_word", w, exp_words[i]);
    end
    chk("t3_fill_empty", fill_level, 0);

    reset_dut();
    trng_req = 1'b1;
    p0 = pulse_cnt;
    repeat (20) @(negedge clk);
    chk("t4_no_valid_empty", pulse_cnt - p0, 0);
    p0 = pulse_cnt;
    add_word(4'h5); run_seq();
    repeat (10) @(negedge clk);
    chk("t4_pulses", pulse_cnt - p0, 1);
    chk("t4_word", last_word, 4'h5);
    trng_req = 1'b0;
    @(negedge clk);

    reset_dut();
    add_word(4'h3); run_seq();
    add_word(4'h6); run_seq();
    chk("t5_fill_two", fill_level, 2);
    for (int i = 0; i < 8; i++) seq.push_back(1);
    run_seq();
    chk("t5_fail", health_fail, 1);
    chk("t5_flushed", fill_level, 0);
    trng_req = 1'b1;
    p0 = pulse_cnt;
    repeat (30) @(negedge clk);
    chk("t5_stalled", pulse_cnt - p0, 0);
    trng_req = 1'b0;
    add_word(4'hA); run_seq();
    chk("t5_no_push", fill_level, 0);
    chk("t5_sticky", health_fail, 1);
    reset_dut();
    chk("t5_cleared", health_fail, 0);

    add_word(4'h9); run_seq();
    chk("t6_fill", fill_level, 1);
    trng_req = 1'b1;
    @(posedge clk);
    #2;
    chk("t6_valid_pending", trng_valid, 1);
    resetn = 1'b0;
    #1;
    chk("t6_valid_cleared", trng_valid, 0);
    chk("t6_word_cleared", trng_word, 0);
    chk("t6_fill_cleared", fill_level, 0);
    trng_req = 1'b0;
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 30; i++) begin raw_bit = ~raw_bit; @(negedge clk); end
    chk("t6_en_off_no_push", fill_level, 0);

    for (int s = 0; s < 6; s++) begin
      mode = s % 3;
      seen = 0;
      en = 1'b1;
      for (int c = 0; c < 500; c++) begin
        case (mode)
          0:       raw_bit = 1'($urandom % 2);
          1:       if ($urandom % 4 != 0) raw_bit = ~raw_bit;
          default: if ($urandom % 8 == 0) raw_bit = ~raw_bit;
        endcase
        if ($urandom % 50 == 0) en = ~en;
        if (trng_req && seen) begin trng_req = 1'b0; seen = 0; end
        else if (trng_req && trng_valid) seen = 1;
        else if (!trng_req && $urandom % 3 == 0) trng_req = 1'b1;
        @(negedge clk);
      end
      @(posedge clk);
      #($urandom_range(1, 4));
      resetn = 1'b0;
      #1;
      chk("rand_reset_valid", trng_valid, 0);
      chk("rand_reset_fill", fill_level, 0);
      chk("rand_reset_fail", health_fail, 0);
      trng_req = 1'b0; en = 1'b0;
      @(negedge clk); @(negedge clk);
      resetn = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
